// File: rtl/pipeline_dbg_pkg.sv
// Shared types for the pipeline self-check unit: FSM states, default widths
// and the check-table entry layout.
package pipeline_dbg_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    HALT = 3'd2,
    READ = 3'd3,
    EMIT = 3'd4,
    DONE = 3'd5
  } state_e;

  typedef struct packed {
    logic                en;
    logic [AW_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0] exp;
  } chk_entry_t;

  // The core stays frozen from the halt point until the next run starts.
  function automatic logic state_halts(input state_e s);
    return (s == HALT) || (s == READ) || (s == EMIT) || (s == DONE);
  endfunction

endpackage

// File: rtl/dbg_check_table.sv
// Check-table storage: one write port, one asynchronous read port,
// every entry cleared on reset.
module dbg_check_table
  import pipeline_dbg_pkg::*;
#(
  parameter int unsigned NCHK = 8,
  parameter int unsigned IW   = $clog2(NCHK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IW-1:0]    widx_i,
  input  chk_entry_t       wdata_i,
  input  logic [IW-1:0]    ridx_i,
  output chk_entry_t       rdata_c_o
);

  chk_entry_t mem_q [NCHK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHK; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[ridx_i];

endmodule

// File: rtl/regfile_check_unit.sv
// Runs the core for a fixed budget, halts and drains it, then reads back and
// checks a programmed list of registers, streaming each result out.
module regfile_check_unit
  import pipeline_dbg_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned NCHK       = 8,
  parameter int unsigned RUN_CYCLES = 20,
  parameter int unsigned DRAIN      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cfg_we,
  input  logic [$clog2(NCHK)-1:0]    cfg_idx,
  input  logic                       cfg_en,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [XLEN-1:0]            cfg_exp,
  output logic                       halt,
  output logic [AW-1:0]              dbg_raddr,
  input  logic [XLEN-1:0]            dbg_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AW-1:0]              out_addr,
  output logic [XLEN-1:0]            out_data,
  output logic                       out_match,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(NCHK+1)-1:0]  fail_count,
  output logic [$clog2(NCHK+1)-1:0]  chk_count
);

  localparam int unsigned IW       = $clog2(NCHK);
  localparam int unsigned CW       = $clog2(NCHK + 1);
  // A zero budget still spends one cycle in RUN and one in HALT.
  localparam int unsigned RUN_LIM  = (RUN_CYCLES == 0) ? 1 : RUN_CYCLES;
  localparam int unsigned DRN_LIM  = (DRAIN == 0) ? 1 : DRAIN;
  localparam int unsigned RW       = $clog2(RUN_LIM + 1);
  localparam int unsigned DW       = $clog2(DRN_LIM + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHK - 1);

  state_e            state_q, state_d;
  logic [RW-1:0]     run_cnt_q, run_cnt_d;
  logic [DW-1:0]     drn_cnt_q, drn_cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  chk_entry_t        cur_q, cur_d;
  chk_entry_t        rd_entry;
  chk_entry_t        tbl_wdata;
  logic              tbl_we;

  logic              halt_q, halt_d;
  logic [AW-1:0]     dbg_raddr_q, dbg_raddr_d;
  logic              out_valid_q, out_valid_d;
  logic [AW-1:0]     out_addr_q, out_addr_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              out_match_q, out_match_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CW-1:0]     fail_q, fail_d;
  logic [CW-1:0]     chk_q, chk_d;

  logic              run_hit, drn_hit, is_last, mismatch, enter_run;

  assign run_hit   = 32'(run_cnt_q) == 32'(RUN_LIM);
  assign drn_hit   = 32'(drn_cnt_q) == 32'(DRN_LIM - 1);
  assign is_last   = idx_q == LAST_IDX;
  assign mismatch  = dbg_rdata != XLEN'(cur_q.exp);
  assign enter_run = (state_d == RUN) && (state_q != RUN);

  // Table writes are only accepted while idle.
  assign tbl_we          = cfg_we && (state_q == IDLE);
  assign tbl_wdata.en    = cfg_en;
  assign tbl_wdata.addr  = AW_DEF'(cfg_addr);
  assign tbl_wdata.exp   = XLEN_DEF'(cfg_exp);

  dbg_check_table #(
    .NCHK (NCHK),
    .IW   (IW)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst),
    .we_i      (tbl_we),
    .widx_i    (cfg_idx),
    .wdata_i   (tbl_wdata),
    .ridx_i    (idx_d),
    .rdata_c_o (rd_entry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (run_hit) state_d = HALT;
      HALT: if (drn_hit) state_d = READ;
      READ: begin
        if (cur_q.en)     state_d = EMIT;
        else if (is_last) state_d = DONE;
      end
      EMIT: if (out_ready) state_d = is_last ? DONE : READ;
      DONE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Counters, index walk and registered outputs.
  always_comb begin
    run_cnt_d   = run_cnt_q;
    drn_cnt_d   = drn_cnt_q;
    idx_d       = idx_q;
    fail_d      = fail_q;
    chk_d       = chk_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_match_d = out_match_q;

    if (enter_run) begin
      run_cnt_d = '0;
      drn_cnt_d = '0;
      idx_d     = '0;
      fail_d    = '0;
      chk_d     = '0;
    end else begin
      unique case (state_q)
        RUN:  if (!run_hit) run_cnt_d = run_cnt_q + RW'(1);
        HALT: if (!drn_hit) drn_cnt_d = drn_cnt_q + DW'(1);
        READ: begin
          if (cur_q.en) begin
            out_addr_d  = AW'(cur_q.addr);
            out_data_d  = dbg_rdata;
            out_match_d = !mismatch;
            chk_d       = chk_q + CW'(1);
            if (mismatch) fail_d = fail_q + CW'(1);
          end else if (!is_last) begin
            idx_d = idx_q + IW'(1);
          end
        end
        EMIT: if (out_ready && !is_last) idx_d = idx_q + IW'(1);
        default: ;
      endcase
    end

    halt_d      = state_halts(state_d);
    out_valid_d = state_d == EMIT;
    done_d      = state_d == DONE;
    pass_d      = done_d && (fail_d == '0);
    // Entry is latched on the way into READ so the read address is registered.
    cur_d       = (state_d == READ) ? rd_entry : cur_q;
    dbg_raddr_d = (state_d == READ) ? AW'(rd_entry.addr) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      idx_q       <= '0;
      cur_q       <= '0;
      halt_q      <= 1'b0;
      dbg_raddr_q <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_match_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= '0;
      chk_q       <= '0;
    end else begin
      run_cnt_q   <= run_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      halt_q      <= halt_d;
      dbg_raddr_q <= dbg_raddr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_match_q <= out_match_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      chk_q       <= chk_d;
    end
  end

  assign halt       = halt_q;
  assign dbg_raddr  = dbg_raddr_q;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign out_match  = out_match_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign chk_count  = chk_q;

endmodule

// File: tb/tb_regfile_check_unit.sv
// Scoreboard bench for regfile_check_unit: directed runs push expected results,
// a negedge monitor compares every presented result against the queue head.
module tb_regfile_check_unit;

  logic        clk = 1'b0;
  logic        rst, start, cfg_we, cfg_en, out_ready;
  logic [2:0]  cfg_idx;
  logic [4:0]  cfg_addr, dbg_raddr, out_addr;
  logic [31:0] cfg_exp, dbg_rdata, out_data;
  logic        halt, out_valid, out_match, done, pass;
  logic [3:0]  fail_count, chk_count;

  logic [31:0] regs [32];

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        match;
  } res_t;

  res_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   results = 0;

  regfile_check_unit #(
    .XLEN(32), .AW(5), .NCHK(8), .RUN_CYCLES(20), .DRAIN(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_addr(cfg_addr), .cfg_exp(cfg_exp), .halt(halt),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .out_match(out_match), .done(done), .pass(pass),
    .fail_count(fail_count), .chk_count(chk_count)
  );

  always #5 clk = ~clk;

  // Register file model: x0 is hard-wired to zero.
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Every presented result is compared with the queue head; popped on handshake.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got addr %0d data 0x%0h, expected no result",
                 out_addr, out_data);
      end else begin
        check("out_addr",  32'(out_addr),  32'(exp_q[0].addr));
        check("out_data",  out_data,       exp_q[0].data);
        check("out_match", 32'(out_match), 32'(exp_q[0].match));
        if (out_ready) begin
          void'(exp_q.pop_front());
          results++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input logic en, input int addr, input int expv);
    cfg_idx  = 3'(idx);
    cfg_en   = en;
    cfg_addr = 5'(addr);
    cfg_exp  = 32'(expv);
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic push(input int addr, input int data, input logic match);
    res_t r;
    r.addr  = 5'(addr);
    r.data  = 32'(data);
    r.match = match;
    exp_q.push_back(r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && out_valid !== 1'b1; i++) tick();
    check("valid_reached", 32'(out_valid), 32'd1);
  endtask

  // Loads the four-entry table; entry 2 expects exp2.
  task automatic load_four(input int exp2);
    cfg_write(0, 1'b1, 5, 5);
    cfg_write(1, 1'b1, 6, 3);
    cfg_write(2, 1'b1, 7, exp2);
    cfg_write(3, 1'b1, 9, 1);
  endtask

  task automatic push_four(input logic m2);
    push(5, 5, 1'b1);
    push(6, 3, 1'b1);
    push(7, 8, m2);
    push(9, 1, 1'b1);
  endtask

  initial begin
    int base;
    rst = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_addr = '0; cfg_exp = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[5] = 32'd5; regs[6] = 32'd3; regs[7] = 32'd8; regs[9] = 32'd1;
    do_reset();

    // Reset state.
    check("rst_halt",      32'(halt),       32'd0);
    check("rst_valid",     32'(out_valid),  32'd0);
    check("rst_done",      32'(done),       32'd0);
    check("rst_pass",      32'(pass),       32'd0);
    check("rst_chk",       32'(chk_count),  32'd0);
    check("rst_fail",      32'(fail_count), 32'd0);
    check("rst_raddr",     32'(dbg_raddr),  32'd0);

    // All matching; last table write lands in the same cycle as start.
    cfg_write(0, 1'b1, 5, 5);
    cfg_write(1, 1'b1, 6, 3);
    cfg_write(2, 1'b1, 7, 8);
    push_four(1'b1);
    cfg_idx = 3'd3; cfg_en = 1'b1; cfg_addr = 5'd9; cfg_exp = 32'd1;
    cfg_we = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    repeat (20) tick();
    check("halt_before_budget", 32'(halt), 32'd0);
    tick();
    check("halt_at_budget", 32'(halt), 32'd1);
    repeat (3) tick();
    check("raddr_in_drain", 32'(dbg_raddr), 32'd0);
    tick();
    check("raddr_first_read", 32'(dbg_raddr), 32'd5);
    wait_done(60);
    check("t1_pass",  32'(pass),       32'd1);
    check("t1_chk",   32'(chk_count),  32'd4);
    check("t1_fail",  32'(fail_count), 32'd0);
    check("t1_left",  32'(exp_q.size()), 32'd0);
    check("t1_count", 32'(results),    32'd4);

    // Entry 2 expects 9; then rerun from DONE with a RUN-time write ignored.
    do_reset();
    load_four(9);
    push_four(1'b0);
    pulse_start();
    wait_done(80);
    check("t2_pass", 32'(pass),       32'd0);
    check("t2_fail", 32'(fail_count), 32'd1);
    check("t2_chk",  32'(chk_count),  32'd4);
    push_four(1'b0);
    pulse_start();
    check("rerun_done_clear", 32'(done), 32'd0);
    check("rerun_chk_clear",  32'(chk_count), 32'd0);
    cfg_write(2, 1'b1, 7, 8);
    wait_done(80);
    check("rerun_pass", 32'(pass),       32'd0);
    check("rerun_fail", 32'(fail_count), 32'd1);
    check("rerun_chk",  32'(chk_count),  32'd4);
    check("t2_left",    32'(exp_q.size()), 32'd0);

    // Back-pressure on the first result for five cycles.
    do_reset();
    load_four(8);
    push_four(1'b1);
    base = results;
    out_ready = 1'b0;
    pulse_start();
    wait_valid(60);
    repeat (5) tick();
    out_ready = 1'b1;
    wait_done(60);
    check("t3_count", 32'(results - base), 32'd4);
    check("t3_left",  32'(exp_q.size()),   32'd0);
    check("t3_pass",  32'(pass),           32'd1);

    // Only entries 1 and 6 enabled: done exactly 35 edges after start.
    do_reset();
    cfg_write(1, 1'b1, 6, 3);
    cfg_write(6, 1'b1, 9, 1);
    push(6, 3, 1'b1);
    push(9, 1, 1'b1);
    base = results;
    pulse_start();
    repeat (34) tick();
    check("t4_done_early", 32'(done), 32'd0);
    tick();
    check("t4_done_time",  32'(done), 32'd1);
    check("t4_chk",   32'(chk_count), 32'd2);
    check("t4_pass",  32'(pass),      32'd1);
    check("t4_count", 32'(results - base), 32'd2);

    // Reset while a result is pending, then an empty-table run.
    do_reset();
    load_four(8);
    push_four(1'b1);
    out_ready = 1'b0;
    pulse_start();
    wait_valid(60);
    #1;
    rst = 1'b0;
    #1;
    check("async_halt",  32'(halt),      32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_done",  32'(done),      32'd0);
    check("async_data",  out_data,       32'd0);
    exp_q.delete();
    base = results;
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    pulse_start();
    wait_done(60);
    check("t5_pass",  32'(pass),       32'd1);
    check("t5_chk",   32'(chk_count),  32'd0);
    check("t5_fail",  32'(fail_count), 32'd0);
    check("t5_count", 32'(results - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_check_unit.md
# regfile_check_unit

Hardware self-check unit for the pipelined RISC-V core. It lets the core run for a programmed cycle budget, halts the pipeline and waits for it to drain, then reads a configurable list of architectural registers through the register file's debug read port. Each value is compared against an expected value and streamed out over a valid/ready port, and the unit finishes with a pass/fail verdict. It sits beside the `Pipeline_RISCV` core and replaces the fixed-time, hand-checked register dumps with a parametrised, in-design checker that works on silicon and in simulation.

## Interface
- `XLEN`, 32: register data width.
- `AW`, 5: register address width (32 architectural registers).
- `NCHK`, 8: number of check-table entries.
- `RUN_CYCLES`, 20: cycles the core runs after `start` before halting.
- `DRAIN`, 4: cycles to wait after halt before the first read.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that launches a run; honoured only in IDLE or DONE.
- `cfg_we` in 1: check-table write strobe; accepted only in IDLE.
- `cfg_idx` in $clog2(NCHK): table entry to write.
- `cfg_en` in 1: entry enable.
- `cfg_addr` in AW: register to check.
- `cfg_exp` in XLEN: expected value.
- `halt` out 1: freezes the core pipeline.
- `dbg_raddr` out AW: register file debug read address.
- `dbg_rdata` in XLEN: combinational read data for `dbg_raddr`.
- `out_valid` out 1, `out_ready` in 1: result stream handshake.
- `out_addr` out AW, `out_data` out XLEN, `out_match` out 1: result payload.
- `done` out 1, `pass` out 1.
- `fail_count` out $clog2(NCHK+1), `chk_count` out $clog2(NCHK+1).

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → HALT when the run counter reaches RUN_CYCLES.
  - HALT → READ when the drain counter reaches DRAIN.
  - READ → EMIT if the entry at `idx` is enabled; otherwise stay in READ with `idx` advanced.
  - EMIT → READ for the next `idx` on handshake, or → DONE if `idx` is the last entry.
  - READ → DONE when a disabled entry is the last entry.
  - DONE → RUN on `start`.
- On every entry to RUN: clear the counters, `idx`, `fail_count`, `chk_count`, `done` and `pass`. The check table is preserved.
- `halt` is 1 in HALT, READ, EMIT and DONE, and 0 in IDLE and RUN.
- In READ, `dbg_raddr` equals the entry's address. In all other states it is 0.
- On READ → EMIT, the unit registers:
  - `out_addr` ← entry address
  - `out_data` ← `dbg_rdata`
  - `out_match` ← (`dbg_rdata` == expected value)
  - `chk_count` incremented by 1
  - `fail_count` incremented by 1 on a mismatch
- Address 0 is checked like any other register; the register file supplies 0.
- `out_valid` is 1 only in EMIT. The payload is stable while `out_valid` is high and `out_ready` is low.
- In DONE: `done` = 1 and `pass` = (`fail_count` == 0). If every entry is disabled, `pass` = 1 with `chk_count` = 0.
- `cfg_we` outside IDLE is ignored. `start` in RUN, HALT, READ or EMIT is ignored.

## Timing
- Reset (`rst` = 0) takes effect immediately, including mid-run:
  - state returns to IDLE
  - every output is 0, so `halt` drops asynchronously
  - all table enables and all counters are 0
- `start` sampled at edge N: the state is RUN from N+1, and `halt` rises at N+1+RUN_CYCLES. With RUN_CYCLES = 0, HALT is entered at N+2.
- The first READ comes DRAIN cycles after HALT is entered.
- An enabled entry costs 1 READ cycle plus at least 1 EMIT cycle. With `out_ready` held at 1, throughput is one result every 2 cycles. A disabled entry costs 1 cycle.
- `done` rises on the cycle after the last handshake, or after the last READ when that entry is disabled.
- A `cfg_we` and a `start` in the same IDLE cycle: the write lands and the run starts with the new table.

## Structure
- Package `pipeline_dbg_pkg`:
  - state enum {IDLE, RUN, HALT, READ, EMIT, DONE}
  - default `XLEN`/`AW`
  - the check-entry struct {en, addr, exp}
- Sub-module `dbg_check_table`: an NCHK-entry register array with a single write port and an asynchronous read port, cleared on reset.
- The FSM, counters and output registers live in the top module.

## Test plan
- Load entries 0–3 = {x5 → 5, x6 → 3, x7 → 8, x9 → 1}, all enabled, `out_ready` held at 1, program matching those values → 4 results, each with `out_match` = 1; `pass` = 1; `chk_count` = 4; `halt` rises exactly 20 cycles after `start`.
- Same setup with entry 2 expecting 9 → entry 2 gives `out_match` = 0 with `out_data` = 8; `fail_count` = 1; `pass` = 0.
- Hold `out_ready` low for 5 cycles on the first result → payload stable throughout; no result lost or duplicated.
- Enable only entries 1 and 6 → exactly 2 results; `done` is reached after the expected number of cycles.
- Pulse `rst` low while in EMIT → `halt`, `out_valid` and `done` drop immediately; the table is cleared; a following `start` with no entries reaches `pass` = 1 with `chk_count` = 0.
- `start` in DONE → a second run repeats; `cfg_we` during RUN leaves the table unchanged.
